seq_shift_unit: RTL

//  Multi-cycle shift/rotate engine for the 16-bit datapath; the sequential

---
 rtl/seq_shift_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/seq_shift_unit.sv
// Sequential shift/rotate engine: one bit position per clock, result on a one-cycle DONE.
// Latency n+1 cycles after the START edge (n = B[CNT_W-1:0]); START is ignored while BUSY.
module seq_shift_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] O,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FIN   = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] step_val;
  logic             busy;
  logic             done;

  // Only the low CNT_W bits of the amount are meaningful.
  logic unused_b_hi;
  assign unused_b_hi = ^B[WIDTH-1:CNT_W];

  always_comb begin
    step_val = work_q;
    case (op_q)
      OP_SLL:  step_val = {work_q[WIDTH-2:0], 1'b0};
      OP_SRL:  step_val = {1'b0, work_q[WIDTH-1:1]};
      OP_SRA:  step_val = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      OP_ROR:  step_val = {work_q[0], work_q[WIDTH-1:1]};
      default: step_val = work_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    o_d     = o_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          work_d = A;
          op_d   = OP;
          cnt_d  = B[CNT_W-1:0];
          if (B[CNT_W-1:0] == CNT_ZERO) begin
            // Zero amount: the operand itself is the result.
            state_d = S_FIN;
            o_d     = A;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        busy   = 1'b1;
        work_d = step_val;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_FIN;
          o_d     = step_val;
        end
      end
      S_FIN: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      o_q     <= '0;
      cnt_q   <= '0;
      op_q    <= OP_SLL;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      o_q     <= o_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  assign O    = o_q;
  assign BUSY = busy;
  assign DONE = done;

endmodule
